// File: rtl/issue_scheduler_pkg.sv
// ============================================================================
// Module   : issue_scheduler_pkg
// Brief    : Shared types and widths for the dual-issue scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package issue_scheduler_pkg;

    localparam int REG_W   = 7;
    localparam int LAT_W   = 3;
    localparam int WORD_W  = 32;
    localparam int NUM_SRC = 3;

    typedef enum logic {
        PIPE_EVEN = 1'b0,
        PIPE_ODD  = 1'b1
    } pipe_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        PAIR   = 2'd1,
        SECOND = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [WORD_W-1:0]             word;
        pipe_t                         pipe;
        logic [REG_W-1:0]              rt;
        logic                          rt_we;
        logic [NUM_SRC-1:0][REG_W-1:0] src;
        logic [NUM_SRC-1:0]            src_use;
        logic [LAT_W-1:0]              lat;
    } issue_slot_t;

    // True when any enabled source of the slot names register r.
    function automatic logic reads_reg(input issue_slot_t slot, input logic [REG_W-1:0] r);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (slot.src_use[k] && (slot.src[k] == r)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/issue_scheduler_if.sv
// ============================================================================
// Module   : issue_scheduler_if
// Brief    : Fetch-side pair handshake and pipe issue bus of the scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface issue_scheduler_if;
    import issue_scheduler_pkg::*;

    logic                                 pair_valid;
    logic                                 pair_ready;
    logic [1:0][WORD_W-1:0]               inst_word;
    logic [1:0]                           inst_pipe;
    logic [1:0][REG_W-1:0]                inst_rt;
    logic [1:0]                           inst_rt_we;
    logic [1:0][NUM_SRC-1:0][REG_W-1:0]   inst_src;
    logic [1:0][NUM_SRC-1:0]              inst_src_use;
    logic [1:0][LAT_W-1:0]                inst_lat;
    logic                                 flush;
    logic                                 even_valid;
    logic [WORD_W-1:0]                    even_inst;
    logic                                 odd_valid;
    logic [WORD_W-1:0]                    odd_inst;
    logic                                 dual_issue;
    logic                                 stall;

    modport master (
        output pair_valid, inst_word, inst_pipe, inst_rt, inst_rt_we,
               inst_src, inst_src_use, inst_lat, flush,
        input  pair_ready, even_valid, even_inst, odd_valid, odd_inst,
               dual_issue, stall
    );

    modport slave (
        input  pair_valid, inst_word, inst_pipe, inst_rt, inst_rt_we,
               inst_src, inst_src_use, inst_lat, flush,
        output pair_ready, even_valid, even_inst, odd_valid, odd_inst,
               dual_issue, stall
    );

endinterface

`default_nettype wire

// File: rtl/issue_scheduler_reg_scoreboard.sv
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Per-register latency counters with two set ports and lookups.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_scoreboard
    import issue_scheduler_pkg::*;
#(
    parameter int NUM_REGS = 128
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [1:0]                         set_en,
    input  logic [1:0][REG_W-1:0]              set_addr,
    input  logic [1:0][LAT_W-1:0]              set_lat,
    input  logic [1:0][NUM_SRC-1:0][REG_W-1:0] src_addr,
    output logic [1:0][NUM_SRC-1:0]            src_busy,
    input  logic [1:0][REG_W-1:0]              rt_addr,
    output logic [1:0]                         rt_busy,
    output logic [1:0][LAT_W-1:0]              rt_count
);

    logic [LAT_W-1:0] r_count [NUM_REGS];

    // A fresh load wins over the per-cycle decrement of the same entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (set_en[0] && (set_addr[0] == REG_W'(i))) begin
                    r_count[i] <= set_lat[0];
                end else if (set_en[1] && (set_addr[1] == REG_W'(i))) begin
                    r_count[i] <= set_lat[1];
                end else if (r_count[i] != '0) begin
                    r_count[i] <= r_count[i] - LAT_W'(1);
                end
            end
        end
    end

    for (genvar s = 0; s < 2; s++) begin : g_port
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
            assign src_busy[s][k] = (r_count[src_addr[s][k]] != '0);
        end
        assign rt_count[s] = r_count[rt_addr[s]];
        assign rt_busy[s]  = (rt_count[s] != '0);
    end

endmodule

`default_nettype wire

// File: rtl/issue_scheduler.sv
// ============================================================================
// Module   : issue_scheduler
// Brief    : One-pair buffer with hazard checks routing to even/odd pipes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int NUM_REGS = 128
) (
    input  logic             clock,
    input  logic             reset,
    issue_scheduler_if.slave bus
);

    sched_state_t                        r_state;
    sched_state_t                        w_next_state;
    issue_slot_t                         r_slot [2];
    issue_slot_t                         w_in_slot [2];

    logic [1:0]                          w_set_en;
    logic [1:0][REG_W-1:0]               w_set_addr;
    logic [1:0][LAT_W-1:0]               w_set_lat;
    logic [1:0][NUM_SRC-1:0][REG_W-1:0]  w_src_addr;
    logic [1:0][NUM_SRC-1:0]             w_src_busy;
    logic [1:0][REG_W-1:0]               w_rt_addr;
    logic [1:0]                          w_rt_busy;
    logic [1:0][LAT_W-1:0]               w_rt_count;

    logic [1:0]                          w_slot_ready;
    logic                                w_raw_pair;
    logic                                w_waw_pair;
    logic                                w_pair_ok;
    logic                                w_issue0;
    logic                                w_issue1;
    logic                                w_dual;
    logic                                w_drain;
    logic                                w_pair_ready;
    logic                                w_accept;

    for (genvar s = 0; s < 2; s++) begin : g_slot
        assign w_in_slot[s] = '{
            word:    bus.inst_word[s],
            pipe:    pipe_t'(bus.inst_pipe[s]),
            rt:      bus.inst_rt[s],
            rt_we:   bus.inst_rt_we[s],
            src:     bus.inst_src[s],
            src_use: bus.inst_src_use[s],
            lat:     bus.inst_lat[s]
        };

        assign w_src_addr[s] = r_slot[s].src;
        assign w_rt_addr[s]  = r_slot[s].rt;

        // The WAW term keeps an older, longer-latency write from landing after this one.
        assign w_slot_ready[s] = ((r_slot[s].src_use & w_src_busy[s]) == '0) &&
                                 (!r_slot[s].rt_we || !w_rt_busy[s] ||
                                  (w_rt_count[s] < r_slot[s].lat));
    end

    assign w_raw_pair = r_slot[0].rt_we && reads_reg(r_slot[1], r_slot[0].rt);
    assign w_waw_pair = r_slot[0].rt_we && r_slot[1].rt_we && (r_slot[0].rt == r_slot[1].rt);
    assign w_pair_ok  = w_slot_ready[1] && (r_slot[0].pipe != r_slot[1].pipe) &&
                        !w_raw_pair && !w_waw_pair;

    assign w_set_en   = {w_issue1 && r_slot[1].rt_we, w_issue0 && r_slot[0].rt_we};
    assign w_set_addr = {r_slot[1].rt, r_slot[0].rt};
    assign w_set_lat  = {r_slot[1].lat, r_slot[0].lat};

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .set_en   (w_set_en),
        .set_addr (w_set_addr),
        .set_lat  (w_set_lat),
        .src_addr (w_src_addr),
        .src_busy (w_src_busy),
        .rt_addr  (w_rt_addr),
        .rt_busy  (w_rt_busy),
        .rt_count (w_rt_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_slot[0] <= '0;
            r_slot[1] <= '0;
        end else if (w_accept) begin
            r_slot[0] <= w_in_slot[0];
            r_slot[1] <= w_in_slot[1];
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_issue0       = 1'b0;
        w_issue1       = 1'b0;
        w_dual         = 1'b0;
        w_drain        = 1'b0;
        bus.even_valid = 1'b0;
        bus.even_inst  = '0;
        bus.odd_valid  = 1'b0;
        bus.odd_inst   = '0;

        case (r_state)
            PAIR: begin
                if (w_slot_ready[0]) begin
                    w_issue0 = 1'b1;
                    if (w_pair_ok) begin
                        w_issue1 = 1'b1;
                        w_dual   = 1'b1;
                        w_drain  = 1'b1;
                    end
                end
            end
            SECOND: begin
                if (w_slot_ready[1]) begin
                    w_issue1 = 1'b1;
                    w_drain  = 1'b1;
                end
            end
            default: ;
        endcase

        // Flush and reset squash issue so no scoreboard entry is loaded.
        if (reset || bus.flush) begin
            w_issue0 = 1'b0;
            w_issue1 = 1'b0;
            w_dual   = 1'b0;
            w_drain  = 1'b0;
        end

        w_pair_ready = !reset && !bus.flush && ((r_state == EMPTY) || w_drain);
        w_accept     = bus.pair_valid && w_pair_ready;

        if (bus.flush) begin
            w_next_state = EMPTY;
        end else if (w_accept) begin
            w_next_state = PAIR;
        end else if (w_drain) begin
            w_next_state = EMPTY;
        end else if (w_issue0) begin
            w_next_state = SECOND;
        end

        if (w_issue0) begin
            if (r_slot[0].pipe == PIPE_ODD) begin
                bus.odd_valid = 1'b1;
                bus.odd_inst  = r_slot[0].word;
            end else begin
                bus.even_valid = 1'b1;
                bus.even_inst  = r_slot[0].word;
            end
        end
        if (w_issue1) begin
            if (r_slot[1].pipe == PIPE_ODD) begin
                bus.odd_valid = 1'b1;
                bus.odd_inst  = r_slot[1].word;
            end else begin
                bus.even_valid = 1'b1;
                bus.even_inst  = r_slot[1].word;
            end
        end

        bus.pair_ready = w_pair_ready;
        bus.dual_issue = w_dual;
        bus.stall      = !reset && !bus.flush && (r_state != EMPTY) && !w_issue0 && !w_issue1;
    end

endmodule

`default_nettype wire

// File: tb/tb_issue_scheduler.sv
// ============================================================================
// Module   : tb_issue_scheduler
// Brief    : Vector table plus hand sequences; issue events checked via queue.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    issue_scheduler_if bus ();

    issue_scheduler #(.NUM_REGS(128)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] w0, w1;
        logic        p0, p1;
        logic [6:0]  rt0, rt1;
        logic        we0, we1;
        logic [6:0]  a0, b0, c0, a1, b1, c1;
        logic [2:0]  u0, u1;
        logic [2:0]  l0, l1;
        int          d0, d1;   // issue cycle after acceptance; d1==0 means never
    } vec_t;

    typedef struct {
        int          cyc;
        logic        ev;
        logic [31:0] ew;
        logic        ov;
        logic [31:0] ow;
        logic        dual;
    } exp_t;

    exp_t expq [$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (bus.even_valid || bus.odd_valid) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: cycle %0d even=%0b odd=%0b, expected no issue",
                         cyc, bus.even_valid, bus.odd_valid);
            end else begin
                mon_e = expq.pop_front();
                chk("issue_cycle", cyc, mon_e.cyc);
                chk("even_valid", bus.even_valid, mon_e.ev);
                chk("even_inst", bus.even_inst, mon_e.ew);
                chk("odd_valid", bus.odd_valid, mon_e.ov);
                chk("odd_inst", bus.odd_inst, mon_e.ow);
                chk("dual_issue", bus.dual_issue, mon_e.dual);
            end
        end else begin
            chk("idle_even_inst", bus.even_inst, 32'h0);
            chk("idle_odd_inst", bus.odd_inst, 32'h0);
        end
    end

    function automatic exp_t add_slot(input exp_t e, input logic p, input logic [31:0] w);
        exp_t r;
        r = e;
        if (p) begin r.ov = 1'b1; r.ow = w; end
        else   begin r.ev = 1'b1; r.ew = w; end
        return r;
    endfunction

    task automatic push(input vec_t v, input int acc);
        exp_t e;
        e = '{cyc: acc + v.d0 - 1, ev: 1'b0, ew: 32'h0, ov: 1'b0, ow: 32'h0, dual: 1'b0};
        if (v.d1 == v.d0) begin
            e.dual = 1'b1;
            e = add_slot(e, v.p0, v.w0);
            e = add_slot(e, v.p1, v.w1);
            expq.push_back(e);
        end else begin
            expq.push_back(add_slot(e, v.p0, v.w0));
            if (v.d1 != 0) begin
                e = '{cyc: acc + v.d1 - 1, ev: 1'b0, ew: 32'h0, ov: 1'b0, ow: 32'h0, dual: 1'b0};
                expq.push_back(add_slot(e, v.p1, v.w1));
            end
        end
    endtask

    task automatic present(input vec_t v);
        bus.pair_valid         = 1'b1;
        bus.inst_word[0]       = v.w0;   bus.inst_word[1]    = v.w1;
        bus.inst_pipe          = {v.p1, v.p0};
        bus.inst_rt[0]         = v.rt0;  bus.inst_rt[1]      = v.rt1;
        bus.inst_rt_we         = {v.we1, v.we0};
        bus.inst_src[0][0]     = v.a0;   bus.inst_src[0][1]  = v.b0;  bus.inst_src[0][2] = v.c0;
        bus.inst_src[1][0]     = v.a1;   bus.inst_src[1][1]  = v.b1;  bus.inst_src[1][2] = v.c1;
        bus.inst_src_use[0]    = v.u0;   bus.inst_src_use[1] = v.u1;
        bus.inst_lat[0]        = v.l0;   bus.inst_lat[1]     = v.l1;
    endtask

    // Presents a pair at the start of a cycle; returns just after the accepting edge.
    task automatic send(input vec_t v, input string nm, output int acc);
        present(v);
        @(negedge clock);
        chk({nm, "_pair_ready"}, bus.pair_ready, 1);
        @(posedge clock);
        #1;
        acc            = cyc;
        bus.pair_valid = 1'b0;
        push(v, acc);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    localparam int NV = 12;
    vec_t vt [NV];
    vec_t vs;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, mx, st;

        //        w0            w1            p0 p1 rt0 rt1 we0 we1 a0 b0 c0  a1 b1 c1  u0      u1      l0 l1 d0 d1
        vt[0]  = '{32'hA000_0001, 32'hB000_0001, 0, 1,  1,  2, 1, 1,  3, 4, 5,  6, 7, 8, 3'b111, 3'b111, 2, 3, 1, 1};
        vt[1]  = '{32'hA000_0002, 32'hB000_0002, 1, 0, 11, 12, 1, 1, 13,14,15, 16,17,18, 3'b011, 3'b011, 4, 4, 1, 1};
        vt[2]  = '{32'hA000_0003, 32'hB000_0003, 0, 0, 21, 22, 1, 1, 23,24, 0, 25,26, 0, 3'b011, 3'b011, 1, 1, 1, 2};
        vt[3]  = '{32'hA000_0004, 32'hB000_0004, 1, 1, 31, 32, 0, 0,  0, 0, 0,  0, 0, 0, 3'b000, 3'b000, 1, 1, 1, 2};
        vt[4]  = '{32'hA000_0005, 32'hB000_0005, 0, 1,  5,  6, 1, 1,  1, 2, 3,  5, 0, 0, 3'b000, 3'b001, 2, 1, 1, 4};
        vt[5]  = '{32'hA000_0006, 32'hB000_0006, 1, 0,  7,  8, 1, 0,  0, 0, 0,  0, 7, 0, 3'b000, 3'b010, 1, 1, 1, 3};
        vt[6]  = '{32'hA000_0007, 32'hB000_0007, 0, 1,  9,  9, 1, 1,  0, 0, 0,  0, 0, 0, 3'b000, 3'b000, 3, 5, 1, 2};
        vt[7]  = '{32'hA000_0008, 32'hB000_0008, 0, 1,  9,  9, 1, 1,  0, 0, 0,  0, 0, 0, 3'b000, 3'b000, 5, 2, 1, 6};
        vt[8]  = '{32'hA000_0009, 32'hB000_0009, 0, 1, 40, 43, 1, 1,  0, 0, 0, 40,41,42, 3'b000, 3'b110, 3, 3, 1, 1};
        vt[9]  = '{32'hA000_000A, 32'hB000_000A, 1, 0, 50, 51, 0, 1,  0, 0, 0,  0, 0,50, 3'b000, 3'b100, 2, 2, 1, 1};
        vt[10] = '{32'hA000_000B, 32'hB000_000B, 0, 1, 60, 61, 1, 0,  0, 0, 0,  0, 0,60, 3'b000, 3'b100, 7, 1, 1, 9};
        vt[11] = '{32'hA000_000C, 32'h0000_0000, 0, 1, 70,  0, 1, 0, 71,72,73,  0, 0, 0, 3'b111, 3'b000, 2, 1, 1, 1};

        bus.pair_valid   = 1'b0;
        bus.inst_word    = '0;
        bus.inst_pipe    = '0;
        bus.inst_rt      = '0;
        bus.inst_rt_we   = '0;
        bus.inst_src     = '0;
        bus.inst_src_use = '0;
        bus.inst_lat     = '0;
        bus.flush        = 1'b0;

        repeat (3) tick();
        @(negedge clock);
        chk("rst_pair_ready", bus.pair_ready, 0);
        chk("rst_even_valid", bus.even_valid, 0);
        chk("rst_odd_valid", bus.odd_valid, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_dual", bus.dual_issue, 0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_pair_ready", bus.pair_ready, 1);
        chk("post_rst_stall", bus.stall, 0);
        tick();

        for (int i = 0; i < NV; i++) begin
            send(vt[i], $sformatf("vec%0d", i), acc);
            mx = (vt[i].d1 > vt[i].d0) ? vt[i].d1 : vt[i].d0;
            st = 0;
            for (int k = 1; k <= mx; k++) begin
                @(negedge clock);
                st += int'(bus.stall);
            end
            chk($sformatf("vec%0d_stall_cycles", i), st,
                (vt[i].d1 > vt[i].d0) ? (vt[i].d1 - vt[i].d0 - 1) : 0);
            repeat (10) tick();
        end

        // Cross-pair RAW: second pair accepted on the dual-issue cycle of the first.
        vs = '{32'hC000_0001, 32'hD000_0001, 0, 1, 10, 11, 1, 0, 0,0,0, 0,0,0, 3'b000, 3'b000, 6, 1, 1, 1};
        send(vs, "xraw_first", acc);
        vs = '{32'hC000_0002, 32'hD000_0002, 0, 1, 12, 13, 0, 0, 10,0,0, 0,0,0, 3'b001, 3'b000, 1, 1, 7, 7};
        send(vs, "xraw_second", acc2);
        chk("xraw_accept_cycle", acc2, acc + 1);
        st = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            st += int'(bus.stall);
        end
        chk("xraw_stall_cycles", st, 6);
        repeat (10) tick();

        // Flush while slot 1 is pending; the issued slot 0 keeps counting down.
        vs = '{32'hE000_0001, 32'hE000_0002, 0, 0, 20, 21, 1, 0, 0,0,0, 0,0,0, 3'b000, 3'b000, 4, 1, 1, 0};
        send(vs, "flush_pair", acc);
        tick();
        bus.flush = 1'b1;
        @(negedge clock);
        chk("flush_even_valid", bus.even_valid, 0);
        chk("flush_odd_valid", bus.odd_valid, 0);
        chk("flush_pair_ready", bus.pair_ready, 0);
        chk("flush_stall", bus.stall, 0);
        tick();
        bus.flush = 1'b0;
        vs = '{32'hE000_0003, 32'hE000_0004, 0, 1, 22, 23, 0, 0, 20,0,0, 0,0,0, 3'b001, 3'b000, 1, 1, 3, 3};
        send(vs, "post_flush", acc);
        repeat (14) tick();

        // Reset while slot 1 is stalled on a 7-cycle producer.
        vs = '{32'hF000_0001, 32'hF000_0002, 0, 1, 30, 31, 1, 0, 0,0,0, 0,30,0, 3'b000, 3'b010, 7, 1, 1, 0};
        send(vs, "rst_pair", acc);
        tick();
        @(negedge clock);
        chk("pre_rst_stall", bus.stall, 1);
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_even_valid", bus.even_valid, 0);
        chk("mid_rst_odd_valid", bus.odd_valid, 0);
        chk("mid_rst_stall", bus.stall, 0);
        chk("mid_rst_pair_ready", bus.pair_ready, 0);
        tick();
        @(negedge clock);
        chk("held_rst_pair_ready", bus.pair_ready, 0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("rel_rst_pair_ready", bus.pair_ready, 1);
        chk("rel_rst_stall", bus.stall, 0);
        tick();
        vs = '{32'hF000_0003, 32'hF000_0004, 0, 1, 32, 33, 0, 0, 30,0,0, 0,0,30, 3'b001, 3'b100, 1, 1, 1, 1};
        send(vs, "after_rst", acc);
        repeat (12) tick();

        chk("pending_issues", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
